// File: rtl/regfile_dbg_port_if.sv
// Interface: regfile_dbg_port_if
//
// Bundles every signal of the register-file debug port: the host command
// channel, the core stall handshake, the Regfile read/write ports and the dump
// stream. The master modport is the debug port's own view. The slave modport is
// the surrounding host, core and Regfile.
//
// Signals (master view):
//   cmd_val/cmd_op/cmd_lo/cmd_hi/cmd_wdata  in   host command
//   cmd_rdy                                 out  command ready
//   stall_req / stall_ack                   out / in   core halt handshake
//   rf_raddr / rf_rdata                     out / in   Regfile read port
//   rf_wen / rf_waddr / rf_wdata            out  Regfile write port
//   out_val/out_addr/out_data / out_rdy     out / in   dump beat stream
//   done / err                              out  completion pulse and reject flag
interface regfile_dbg_port_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          cmd_val;
    logic          cmd_rdy;
    logic          cmd_op;
    logic [AW-1:0] cmd_lo;
    logic [AW-1:0] cmd_hi;
    logic [DW-1:0] cmd_wdata;
    logic          stall_req;
    logic          stall_ack;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          out_val;
    logic          out_rdy;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          done;
    logic          err;

    modport master (
        input  cmd_val, cmd_op, cmd_lo, cmd_hi, cmd_wdata, stall_ack, rf_rdata, out_rdy,
        output cmd_rdy, stall_req, rf_raddr, rf_wen, rf_waddr, rf_wdata,
        output out_val, out_addr, out_data, done, err
    );

    modport slave (
        output cmd_val, cmd_op, cmd_lo, cmd_hi, cmd_wdata, stall_ack, rf_rdata, out_rdy,
        input  cmd_rdy, stall_req, rf_raddr, rf_wen, rf_waddr, rf_wdata,
        input  out_val, out_addr, out_data, done, err
    );
endinterface

// File: rtl/regfile_dbg_port.sv
// Module: regfile_dbg_port
//
// Debug-side master for the processor register file. A dump command (op=0)
// reads registers lo..hi and streams each one as an (addr, data) beat. A write
// command (op=1) pokes one register, and a write to x0 is dropped. Before any
// access, the core is halted through stall_req/stall_ack. A dump with lo > hi
// is rejected straight from idle with done+err and never touches the core.
//
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   bus  regfile_dbg_port_if.master: command, stall handshake, Regfile ports,
//        dump stream, done/err
module regfile_dbg_port #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = $clog2(NREGS),
    parameter int unsigned DW    = 32
) (
    input logic                clk,
    input logic                rst,
    regfile_dbg_port_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRead,
        StSend,
        StWrite,
        StFin
    } state_e;

    state_e        state_q;
    logic          op_q;
    logic [AW-1:0] lo_q;
    logic [AW-1:0] hi_q;
    logic [AW-1:0] ptr_q;
    logic [DW-1:0] wdata_q;
    logic          stall_req_q;
    logic          rf_wen_q;
    logic [AW-1:0] rf_waddr_q;
    logic [DW-1:0] rf_wdata_q;
    logic          out_val_q;
    logic [AW-1:0] out_addr_q;
    logic [DW-1:0] out_data_q;
    logic          done_q;
    logic          err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            ptr_q       <= '0;
            wdata_q     <= '0;
            stall_req_q <= 1'b0;
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            out_val_q   <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // done/err and rf_wen are single-cycle pulses.
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rf_wen_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_val) begin
                        op_q    <= bus.cmd_op;
                        lo_q    <= bus.cmd_lo;
                        hi_q    <= bus.cmd_hi;
                        ptr_q   <= bus.cmd_lo;
                        wdata_q <= bus.cmd_wdata;
                        if (!bus.cmd_op && (bus.cmd_lo > bus.cmd_hi)) begin
                            // Empty range: reject without halting the core.
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            stall_req_q <= 1'b1;
                            state_q     <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (bus.stall_ack) begin
                        if (op_q) begin
                            rf_wen_q   <= (lo_q != '0);
                            rf_waddr_q <= lo_q;
                            rf_wdata_q <= wdata_q;
                            state_q    <= StWrite;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StRead: begin
                    // rf_raddr follows ptr, so rf_rdata already holds x[ptr].
                    out_data_q <= bus.rf_rdata;
                    out_addr_q <= ptr_q;
                    out_val_q  <= 1'b1;
                    state_q    <= StSend;
                end
                StSend: begin
                    if (bus.out_rdy) begin
                        out_val_q <= 1'b0;
                        if (ptr_q == hi_q) begin
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            ptr_q   <= ptr_q + AW'(1);
                            state_q <= StRead;
                        end
                    end
                end
                StWrite: begin
                    done_q  <= 1'b1;
                    state_q <= StFin;
                end
                StFin: begin
                    stall_req_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_rdy   = (state_q == StIdle);
    assign bus.stall_req = stall_req_q;
    assign bus.rf_raddr  = ptr_q;
    assign bus.rf_wen    = rf_wen_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.out_val   = out_val_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Testbench: tb_regfile_dbg_port
//
// Directed bench for regfile_dbg_port. The bench supplies the Regfile memory and
// the core stall responder. A command-level model turns each issued command into
// the expected beats, writes and done/err flags. One compare process checks the
// DUT against these expectations on every clock cycle. Literal expectations in
// each test pin down the model.
module tb_regfile_dbg_port;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_dbg_port_if #(.AW(AW), .DW(DW)) bus ();

    regfile_dbg_port #(.NREGS(32), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file seen by the DUT, and the architectural contents it must hold.
    logic [DW-1:0] rf_mem [32];
    logic [DW-1:0] gold   [32];
    assign bus.rf_rdata = (bus.rf_raddr == '0) ? '0 : rf_mem[bus.rf_raddr];

    int    checks    = 0;
    int    errors    = 0;
    beat_t exp_beats[$];
    beat_t exp_wr[$];
    logic  exp_done[$];
    beat_t acc[$];
    int    done_cnt  = 0;
    int    done_base = 0;
    int    wen_cnt   = 0;
    int    hold_cnt  = 0;
    logic  stall_seen = 1'b0;
    logic  last_err   = 1'b0;
    int    ack_delay  = 0;
    int    rdy_mode   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endtask

    // Environment: Regfile writes, stall responder, out_rdy pattern.
    initial begin
        int ack_cnt;
        ack_cnt = 0;
        for (int i = 0; i < 32; i++) rf_mem[i] = {4{i[7:0]}};
        rf_mem[0]  = '0;
        rf_mem[1]  = 32'h0000_0011;
        rf_mem[2]  = 32'h0000_0022;
        rf_mem[3]  = 32'h0000_0033;
        rf_mem[30] = 32'h3030_3030;
        rf_mem[31] = 32'h3131_3131;
        for (int i = 0; i < 32; i++) gold[i] = rf_mem[i];
        bus.stall_ack = 1'b0;
        bus.out_rdy   = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.stall_req !== 1'b1) begin
                bus.stall_ack = 1'b0;
                ack_cnt       = 0;
            end else if (ack_cnt >= ack_delay) begin
                bus.stall_ack = 1'b1;
            end else begin
                ack_cnt++;
            end
            case (rdy_mode)
                1:       bus.out_rdy = ~bus.out_rdy;
                2:       bus.out_rdy = 1'b0;
                default: bus.out_rdy = 1'b1;
            endcase
            @(negedge clk);
            if (rst === 1'b0 && bus.rf_wen === 1'b1 && bus.rf_waddr != '0)
                rf_mem[bus.rf_waddr] = bus.rf_wdata;
        end
    end

    // Compare process: every cycle out of reset.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (bus.out_val || bus.rf_wen) chk("stall_held", bus.stall_req, 1'b1);
            if (bus.stall_req) stall_seen = 1'b1;
            if (bus.out_val) begin
                if (exp_beats.size() == 0) begin
                    fail("unexpected_beat");
                end else begin
                    chk("beat_addr", bus.out_addr, exp_beats[0].addr);
                    chk("beat_data", bus.out_data, exp_beats[0].data);
                    if (bus.out_rdy) begin
                        b.addr = bus.out_addr;
                        b.data = bus.out_data;
                        acc.push_back(b);
                        void'(exp_beats.pop_front());
                    end else begin
                        hold_cnt++;
                    end
                end
            end
            if (bus.rf_wen) begin
                wen_cnt++;
                if (exp_wr.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    chk("wr_addr", bus.rf_waddr, exp_wr[0].addr);
                    chk("wr_data", bus.rf_wdata, exp_wr[0].data);
                    void'(exp_wr.pop_front());
                end
            end
            if (bus.done) begin
                done_cnt++;
                last_err = bus.err;
                if (exp_done.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    chk("done_err", bus.err, exp_done[0]);
                    void'(exp_done.pop_front());
                end
            end else if (bus.err) begin
                fail("err_without_done");
            end
        end
    end

    // Issue one command and record its expected effects.
    task automatic issue(input logic op, input int lo, input int hi, input logic [DW-1:0] wd);
        int    n;
        beat_t b;
        n = 0;
        while (bus.cmd_rdy !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("cmd_rdy_wait", bus.cmd_rdy, 1'b1);
        if (!op) begin
            if (lo > hi) begin
                exp_done.push_back(1'b1);
            end else begin
                for (int a = lo; a <= hi; a++) begin
                    b.addr = a[AW-1:0];
                    b.data = gold[a];
                    exp_beats.push_back(b);
                end
                exp_done.push_back(1'b0);
            end
        end else begin
            if (lo != 0) begin
                b.addr = lo[AW-1:0];
                b.data = wd;
                exp_wr.push_back(b);
                gold[lo] = wd;
            end
            exp_done.push_back(1'b0);
        end
        done_base     = done_cnt;
        bus.cmd_val   = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_lo    = lo[AW-1:0];
        bus.cmd_hi    = hi[AW-1:0];
        bus.cmd_wdata = wd;
        @(posedge clk);
        #1;
        bus.cmd_val = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (done_cnt == done_base && cycles < 300) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        chk({name, "_done"}, 64'(done_cnt > done_base), 64'd1);
    endtask

    initial begin
        int n;
        int w0;
        rst           = 1'b1;
        bus.cmd_val   = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_lo    = '0;
        bus.cmd_hi    = '0;
        bus.cmd_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_rdy",   bus.cmd_rdy,   1'b1);
        chk("rst_stall_req", bus.stall_req, 1'b0);
        chk("rst_out_val",   bus.out_val,   1'b0);
        chk("rst_rf_wen",    bus.rf_wen,    1'b0);
        chk("rst_done",      bus.done,      1'b0);
        chk("rst_err",       bus.err,       1'b0);
        chk("rst_rf_raddr",  bus.rf_raddr,  '0);
        chk("rst_rf_waddr",  bus.rf_waddr,  '0);
        chk("rst_rf_wdata",  bus.rf_wdata,  '0);
        chk("rst_out_addr",  bus.out_addr,  '0);
        chk("rst_out_data",  bus.out_data,  '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: dump 1..3 with a delayed stall acknowledge.
        ack_delay  = 2;
        rdy_mode   = 0;
        stall_seen = 1'b0;
        acc.delete();
        issue(1'b0, 1, 3, '0);
        wait_done("t1", n);
        chk("t1_beats", acc.size(), 3);
        if (acc.size() == 3) begin
            chk("t1_b0", acc[0], {5'd1, 32'h11});
            chk("t1_b1", acc[1], {5'd2, 32'h22});
            chk("t1_b2", acc[2], {5'd3, 32'h33});
        end
        chk("t1_err", last_err, 1'b0);
        chk("t1_stall_seen", stall_seen, 1'b1);
        @(negedge clk);
        chk("t1_stall_fall", bus.stall_req, 1'b0);
        chk("t1_cmd_rdy", bus.cmd_rdy, 1'b1);

        // 2: write x5 and read it back.
        ack_delay = 1;
        w0 = wen_cnt;
        issue(1'b1, 5, 0, 32'hDEAD_BEEF);
        wait_done("t2w", n);
        chk("t2_wen_cycles", wen_cnt - w0, 1);
        chk("t2_rf_x5", rf_mem[5], 32'hDEAD_BEEF);
        acc.delete();
        issue(1'b0, 5, 5, '0);
        wait_done("t2r", n);
        chk("t2_beats", acc.size(), 1);
        if (acc.size() == 1) chk("t2_b0", acc[0], {5'd5, 32'hDEAD_BEEF});

        // 3: write to x0 is suppressed but completes.
        w0 = wen_cnt;
        issue(1'b1, 0, 0, 32'hFFFF_FFFF);
        wait_done("t3w", n);
        chk("t3_wen_cycles", wen_cnt - w0, 0);
        chk("t3_err", last_err, 1'b0);
        acc.delete();
        issue(1'b0, 0, 0, '0);
        wait_done("t3r", n);
        chk("t3_beats", acc.size(), 1);
        if (acc.size() == 1) chk("t3_b0", acc[0], {5'd0, 32'h0});

        // 4: dump 30..31 with out_rdy toggling, no wrap past x31.
        rdy_mode = 1;
        hold_cnt = 0;
        acc.delete();
        issue(1'b0, 30, 31, '0);
        wait_done("t4", n);
        chk("t4_beats", acc.size(), 2);
        if (acc.size() == 2) begin
            chk("t4_b0", acc[0], {5'd30, 32'h3030_3030});
            chk("t4_b1", acc[1], {5'd31, 32'h3131_3131});
        end
        chk("t4_held", 64'(hold_cnt > 0), 64'd1);
        rdy_mode = 0;
        repeat (4) @(negedge clk);
        chk("t4_no_extra", acc.size(), 2);

        // 5: empty range is rejected the next cycle without stalling.
        stall_seen = 1'b0;
        issue(1'b0, 7, 4, '0);
        wait_done("t5", n);
        chk("t5_latency", n, 1);
        chk("t5_err", last_err, 1'b1);
        repeat (3) @(negedge clk);
        chk("t5_no_stall", stall_seen, 1'b0);

        // 6: reset while a beat is held in SEND.
        ack_delay = 0;
        rdy_mode  = 2;
        issue(1'b0, 0, 31, '0);
        n = 0;
        while (bus.out_val !== 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t6_in_send", bus.out_val, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_beats.delete();
        exp_done.delete();
        exp_wr.delete();
        #1;
        chk("t6_out_val_low", bus.out_val, 1'b0);
        chk("t6_stall_low", bus.stall_req, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        chk("t6_cmd_rdy", bus.cmd_rdy, 1'b1);
        chk("t6_stall_idle", bus.stall_req, 1'b0);
        acc.delete();
        issue(1'b0, 2, 2, '0);
        wait_done("t6", n);
        chk("t6_beats", acc.size(), 1);
        if (acc.size() == 1) chk("t6_b0", acc[0], {5'd2, 32'h22});

        repeat (3) @(negedge clk);
        chk("end_beats_drained", exp_beats.size(), 0);
        chk("end_done_drained", exp_done.size(), 0);
        chk("end_wr_drained", exp_wr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
